clkscale_bank: RTL and testbench

Parametrised multi-channel clock divider producing NCH independent 50 %-duty divided clocks from the single system clock, each with a run-time programmable divisor, glitch-free divisor update at period boundaries, and a global phase-realignment strobe. Sits beside the LFSR and other slow-rate logic, feeding them scaled clocks and optional one-cycle tick enables.

---
 rtl/clkscale_pkg.sv | 14 +
 rtl/clkscale_if.sv | 15 +
 rtl/clkscale_chan.sv | 76 +++++++
 rtl/clkscale_bank.sv | 36 +++
 tb/tb_clkscale_bank.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/clkscale_pkg.sv
// Shared constants and helpers for the clkscale_bank divider slice.
package clkscale_pkg;

    localparam int unsigned DIV_W_DFLT   = 3;
    localparam int unsigned DEF_DIV_DFLT = 0;

    typedef logic [DIV_W_DFLT-1:0] div_t;

    // LSB of channel k's field inside a packed per-channel vector.
    function automatic int unsigned fld_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/clkscale_if.sv
// Control/status bundle of clkscale_bank: master drives controls, slave is the divider bank.
interface clkscale_if #(
    parameter int unsigned NCH   = 3,
    parameter int unsigned DIV_W = clkscale_pkg::DIV_W_DFLT
);
    logic                 en;
    logic                 sync;
    logic [NCH-1:0]       load;
    logic [NCH*DIV_W-1:0] div_i;
    logic [NCH-1:0]       newclk;
    logic [NCH-1:0]       tick;

    modport master (output en, sync, load, div_i, input newclk, tick);
    modport slave  (input en, sync, load, div_i, output newclk, tick);
endinterface

// File: rtl/clkscale_chan.sv
// One divider channel: 50 % duty clock with divisor swapped only on rising newclk.
// Tick generation is present only when CLKSCALE_TICK_EN is defined.
module clkscale_chan #(
    parameter int unsigned DIV_W   = clkscale_pkg::DIV_W_DFLT,
    parameter int unsigned DEF_DIV = clkscale_pkg::DEF_DIV_DFLT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             newclk,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act;
    logic [DIV_W-1:0] pend;
    logic             pend_valid;

    logic             wrap;
    logic             rise;
    logic             have_next;
    logic [DIV_W-1:0] next_div;

    always_comb begin
        wrap      = en && (cnt == act);
        rise      = wrap && !newclk;
        have_next = load || pend_valid;
        // A same-cycle load beats the older pending value.
        next_div  = load ? div : pend;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            act        <= DIV_W'(DEF_DIV);
            pend       <= DIV_W'(DEF_DIV);
            pend_valid <= 1'b0;
            newclk     <= 1'b0;
        end else begin
            if (load) begin
                pend <= div;
            end
            pend_valid <= (sync || rise) ? 1'b0 : (pend_valid || load);
            if (sync) begin
                cnt    <= '0;
                newclk <= 1'b0;
                if (have_next) begin
                    act <= next_div;
                end
            end else if (wrap) begin
                cnt    <= '0;
                newclk <= !newclk;
                if (rise && have_next) begin
                    act <= next_div;
                end
            end else if (en) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef CLKSCALE_TICK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick <= 1'b0;
        end else begin
            tick <= rise && !sync;
        end
    end
`else
    assign tick = 1'b0;
`endif

endmodule

// File: rtl/clkscale_bank.sv
// NCH independent programmable clock dividers with shared enable and phase-realign strobe.
// Define CLKSCALE_TICK_EN to build the per-channel tick pulses.
module clkscale_bank
    import clkscale_pkg::*;
#(
    parameter int unsigned NCH     = 3,
    parameter int unsigned DIV_W   = DIV_W_DFLT,
    parameter int unsigned DEF_DIV = DEF_DIV_DFLT
) (
    input  logic       clk,
    input  logic       reset,
    clkscale_if.slave  bus
);
    logic [NCH-1:0] newclk_w;
    logic [NCH-1:0] tick_w;

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        clkscale_chan #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .en     (bus.en),
            .sync   (bus.sync),
            .load   (bus.load[k]),
            .div    (bus.div_i[fld_lsb(k, DIV_W) +: DIV_W]),
            .newclk (newclk_w[k]),
            .tick   (tick_w[k])
        );
    end

    assign bus.newclk = newclk_w;
    assign bus.tick   = tick_w;

endmodule

// File: tb/tb_clkscale_bank.sv
// Randomised bench for clkscale_bank: phase/duration model plus literal timeline checks.
module tb_clkscale_bank;
    localparam int unsigned NCH     = 3;
    localparam int unsigned DIV_W   = 3;
    localparam int unsigned DEF_DIV = 0;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    clkscale_if #(.NCH(NCH), .DIV_W(DIV_W)) bus ();

    clkscale_bank #(
        .NCH     (NCH),
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: each channel is a level plus cycles remaining in the current half period.
    int m_act [NCH];
    int m_pend[NCH];
    bit m_pv  [NCH];
    bit m_lvl [NCH];
    int m_rem [NCH];
    bit m_tick[NCH];

    task automatic model_step();
        for (int k = 0; k < NCH; k++) begin
            bit lv;
            bit applied;
            int dv;
            if (reset) begin
                m_act[k]  = DEF_DIV;
                m_pend[k] = DEF_DIV;
                m_pv[k]   = 0;
                m_lvl[k]  = 0;
                m_rem[k]  = DEF_DIV + 1;
                m_tick[k] = 0;
            end else begin
                lv = bus.load[k];
                dv = int'(bus.div_i[k*DIV_W +: DIV_W]);
                m_tick[k] = 0;
                if (bus.sync) begin
                    m_lvl[k] = 0;
                    if (lv) m_act[k] = dv;
                    else if (m_pv[k]) m_act[k] = m_pend[k];
                    m_pv[k] = 0;
                    if (lv) m_pend[k] = dv;
                    m_rem[k] = m_act[k] + 1;
                end else begin
                    applied = 0;
                    if (bus.en) begin
                        m_rem[k]--;
                        if (m_rem[k] == 0) begin
                            if (!m_lvl[k]) begin
                                m_lvl[k]  = 1;
                                m_tick[k] = 1;
                                if (lv) m_act[k] = dv;
                                else if (m_pv[k]) m_act[k] = m_pend[k];
                                m_pv[k] = 0;
                                applied = 1;
                            end else begin
                                m_lvl[k] = 0;
                            end
                            m_rem[k] = m_act[k] + 1;
                        end
                    end
                    if (lv) begin
                        m_pend[k] = dv;
                        if (!applied) m_pv[k] = 1;
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // Continuous comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < NCH; k++) begin
            bit exp_tick;
`ifdef CLKSCALE_TICK_EN
            exp_tick = m_tick[k];
`else
            exp_tick = 1'b0;
`endif
            check($sformatf("model newclk[%0d]", k), 32'(bus.newclk[k]), 32'(m_lvl[k]));
            check($sformatf("model tick[%0d]", k), 32'(bus.tick[k]), 32'(exp_tick));
        end
    end

    initial begin
        bus.en    = 1'b0;
        bus.sync  = 1'b0;
        bus.load  = '0;
        bus.div_i = '0;

        repeat (5) @(negedge clk);
        check("reset newclk", 32'(bus.newclk), 32'h0);
        check("reset tick", 32'(bus.tick), 32'h0);
        reset = 1'b0;

        // Program divisors 0/3/7 with a realign, then run.
        bus.load  = '1;
        bus.sync  = 1'b1;
        bus.div_i = {3'd7, 3'd3, 3'd0};
        @(negedge clk);
        check("sync clears", 32'(bus.newclk), 32'h0);
        bus.load = '0;
        bus.sync = 1'b0;
        bus.en   = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            check($sformatf("div0 edge %0d", n), 32'(bus.newclk[0]), 32'(n % 2));
            check($sformatf("div3 edge %0d", n), 32'(bus.newclk[1]), 32'((n / 4) % 2));
            check($sformatf("div7 edge %0d", n), 32'(bus.newclk[2]), 32'((n / 8) % 2));
        end

        // Channel 1 gets divisor 1 mid-high: old period finishes, new one starts at edge 28.
        for (int n = 17; n <= 32; n++) begin
            if (n == 21) begin
                bus.load  = 3'b010;
                bus.div_i = {3'd7, 3'd1, 3'd0};
            end
            @(negedge clk);
            if (n == 21) bus.load = '0;
            if (n == 27) check("chg low e27", 32'(bus.newclk[1]), 32'h0);
            if (n == 28) check("chg rise e28", 32'(bus.newclk[1]), 32'h1);
            if (n == 29) check("chg high e29", 32'(bus.newclk[1]), 32'h1);
            if (n == 30) check("chg fall e30", 32'(bus.newclk[1]), 32'h0);
            if (n == 32) check("chg rise e32", 32'(bus.newclk[1]), 32'h1);
        end

        // Random traffic against the model.
        repeat (400) begin
            bus.en    = ($urandom_range(0, 3) != 0);
            bus.sync  = ($urandom_range(0, 24) == 0);
            bus.load  = NCH'($urandom & $urandom & $urandom);
            bus.div_i = (NCH*DIV_W)'($urandom);
            @(negedge clk);
        end

        // Realign all channels (arbitrary phases) to divisor 2.
        bus.en    = 1'b1;
        bus.load  = '1;
        bus.sync  = 1'b1;
        bus.div_i = {3'd2, 3'd2, 3'd2};
        @(negedge clk);
        check("sync all low", 32'(bus.newclk), 32'h0);
        bus.load = '0;
        bus.sync = 1'b0;
        @(negedge clk);
        check("sync e1", 32'(bus.newclk), 32'h0);
        @(negedge clk);
        check("sync e2", 32'(bus.newclk), 32'h0);
        @(negedge clk);
        check("sync rise together", 32'(bus.newclk), 32'h7);
        @(negedge clk);
        check("high e4", 32'(bus.newclk), 32'h7);

        // Freeze five cycles mid-high: level holds, no ticks, period stretches.
        bus.en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("hold newclk", 32'(bus.newclk), 32'h7);
            check("hold tick", 32'(bus.tick), 32'h0);
        end
        bus.en = 1'b1;
        @(negedge clk);
        check("resume high", 32'(bus.newclk), 32'h7);
        @(negedge clk);
        check("resume fall", 32'(bus.newclk), 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("low before rise", 32'(bus.newclk), 32'h0);

        // Asynchronous reset just after a rising edge.
        @(posedge clk);
        #5;
        check("pre reset high", 32'(bus.newclk), 32'h7);
        reset = 1'b1;
        #1;
        check("async reset newclk", 32'(bus.newclk), 32'h0);
        check("async reset tick", 32'(bus.tick), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post reset def div e1", 32'(bus.newclk), 32'h7);
        @(negedge clk);
        check("post reset def div e2", 32'(bus.newclk), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
